seg2_scan: RTL

Two-digit multiplexed seven-segment display driver: the display-side consumer of the 0–9 key press counts. It accepts two 4-bit BCD digit values with a load strobe and buffers them so the display never tears. It time-multiplexes the two digits onto a shared segment bus with anti-ghost blanking gaps. It sits between the key counting logic and the board's common-anode/cathode digit pins.

---
 rtl/seg2_scan_pkg.sv | 40 ++++
 rtl/seg7_decode.sv | 28 ++
 rtl/seg2_scan.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seg2_scan_pkg.sv
// seg2_scan shared definitions: scan states and
// seven-segment patterns, bit order {g,f,e,d,c,b,a}.
package seg2_scan_pkg;

    typedef enum logic [1:0] {
        S_DIG0 = 2'd0,
        S_GAP0 = 2'd1,
        S_DIG1 = 2'd2,
        S_GAP1 = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Map an active-high pin vector onto the board polarity.
    function automatic logic [7:0] pol8(
        input logic [7:0] v,
        input logic       act_low
    );
        return act_low ? ~v : v;
    endfunction

    function automatic logic [1:0] pol2(
        input logic [1:0] v,
        input logic       act_low
    );
        return act_low ? ~v : v;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-high seven-segment pattern.
// Non-decimal codes show a dash.
module seg7_decode
    import seg2_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pat
);

    // Pure lookup, no state.
    always_comb begin
        pat = SEG_DASH;
        unique case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg2_scan.sv
// Two-digit multiplexed seven-segment driver with
// frame-synchronous buffering and blanking gaps.
module seg2_scan
    import seg2_scan_pkg::*;
#(
    parameter int SCAN_DIV    = 12000,
    parameter int BLANK_GAP   = 120,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic       load,
    input  logic       blank_lz,
    output logic [7:0] seg,
    output logic [1:0] dig
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_LAST = SCAN_DIV - BLANK_GAP - 1;
    localparam int GAP_LAST = (BLANK_GAP > 0) ? BLANK_GAP - 1 : 0;
    localparam bit HAS_GAP = (BLANK_GAP > 0);
    localparam logic SEG_LOW = (SEG_ACT_LOW != 0);
    localparam logic DIG_LOW = (DIG_ACT_LOW != 0);
    localparam logic [7:0] SEG_IDLE = pol8(8'h00, SEG_LOW);
    localparam logic [1:0] DIG_IDLE = pol2(2'b00, DIG_LOW);

    scan_state_t state;
    scan_state_t state_nxt;
    logic [CW-1:0] cnt;
    logic [7:0] shadow;
    logic [7:0] active;
    logic slot_done;
    logic frame_start;

    logic [3:0] cur_digit;
    logic [6:0] cur_pat;
    logic [6:0] seg_pat;
    logic [1:0] dig_on;
    logic [7:0] seg_d;
    logic [1:0] dig_d;

    // Slot end detection and the fixed DIG0..GAP1 rotation.
    always_comb begin
        slot_done = 1'b0;
        state_nxt = state;
        unique case (state)
            S_DIG0: begin
                slot_done = (cnt == CW'(DIG_LAST));
                if (slot_done)
                    state_nxt = HAS_GAP ? S_GAP0 : S_DIG1;
            end
            S_GAP0: begin
                slot_done = !HAS_GAP || (cnt == CW'(GAP_LAST));
                if (slot_done)
                    state_nxt = S_DIG1;
            end
            S_DIG1: begin
                slot_done = (cnt == CW'(DIG_LAST));
                if (slot_done)
                    state_nxt = HAS_GAP ? S_GAP1 : S_DIG0;
            end
            S_GAP1: begin
                slot_done = !HAS_GAP || (cnt == CW'(GAP_LAST));
                if (slot_done)
                    state_nxt = S_DIG0;
            end
            default: begin
                slot_done = 1'b1;
                state_nxt = S_GAP1;
            end
        endcase
    end

    assign frame_start = (state_nxt == S_DIG0) && (state != S_DIG0);

    // State register; the counter restarts on every state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_GAP1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    // Shadow follows every load; active only moves at a frame start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (load)
                shadow <= {digit1, digit0};
            if (frame_start)
                active <= load ? {digit1, digit0} : shadow;
        end
    end

    assign cur_digit = (state == S_DIG1) ? active[7:4] : active[3:0];

    seg7_decode u_dec (
        .bcd (cur_digit),
        .pat (cur_pat)
    );

    // Pick the lit digit and its pattern for the current slot.
    always_comb begin
        seg_pat = SEG_OFF;
        dig_on  = 2'b00;
        unique case (state)
            S_DIG0: begin
                seg_pat = cur_pat;
                dig_on  = 2'b01;
            end
            S_DIG1: begin
                if (blank_lz && (active[7:4] == 4'd0))
                    seg_pat = SEG_OFF;
                else
                    seg_pat = cur_pat;
                dig_on = 2'b10;
            end
            default: begin
                seg_pat = SEG_OFF;
                dig_on  = 2'b00;
            end
        endcase
        seg_d = pol8({1'b0, seg_pat}, SEG_LOW);
        dig_d = pol2(dig_on, DIG_LOW);
    end

    // Pins change together on one edge, so no ghost mixes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg <= SEG_IDLE;
            dig <= DIG_IDLE;
        end else begin
            seg <= seg_d;
            dig <= dig_d;
        end
    end

endmodule
